// File: rtl/ascon_pkg.sv
// Shared ASCON data-path constants and types used by the rate packer and its block FIFO.
package ascon_pkg;

    localparam int unsigned ASCON_WORD_W = 32;
    localparam int unsigned ASCON_RATE_W = 64;
    localparam logic [ASCON_WORD_W-1:0] ASCON_PAD_WORD = 32'h8000_0000;

    typedef struct packed {
        logic [ASCON_RATE_W-1:0] data;
        logic                    last;
    } ascon_blk_t;

    typedef enum logic {
        ASM_EMPTY = 1'b0,
        ASM_HALF  = 1'b1
    } asm_state_e;

endpackage

// File: rtl/ascon_blk_fifo.sv
// Synchronous FIFO of ASCON rate blocks; a full FIFO may still accept a push when popped the same cycle.
module ascon_blk_fifo
    import ascon_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  ascon_blk_t       push_data_i,
    input  logic             pop_i,
    output ascon_blk_t       head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    ascon_blk_t       mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == LVL_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + LVL_W'(1);
            2'b01:   cnt_d = cnt_q - LVL_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only observed once counted valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ascon_rate_packer.sv
// Packs 32-bit register-block words into padded 64-bit ASCON-128 rate blocks behind a small FIFO.
module ascon_rate_packer
    import ascon_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic [ASCON_WORD_W-1:0] data_in_i,
    input  logic                    data_in_valid_i,
    input  logic                    flush_i,
    output logic [ASCON_RATE_W-1:0] block_o,
    output logic                    block_last_o,
    output logic                    block_valid_o,
    input  logic                    block_ready_i,
    output logic [LVL_W-1:0]        level_o,
    output logic                    half_o,
    output logic                    overflow_o
);

    asm_state_e              state_q, state_d;
    logic [ASCON_WORD_W-1:0] held_q, held_d;
    logic                    flush_pend_q, flush_pend_d;
    logic                    overflow_q, overflow_d;

    logic       push_c;
    logic       word_push_c;
    logic       pop_c;
    logic       can_push_c;
    logic       fifo_full;
    logic       fifo_empty;
    ascon_blk_t push_blk_c;
    ascon_blk_t head;

    assign block_valid_o = !fifo_empty;
    assign pop_c         = block_valid_o && block_ready_i;
    assign can_push_c    = !fifo_full || pop_c;
    assign block_o       = head.data;
    assign block_last_o  = head.last;
    assign half_o        = (state_q == ASM_HALF);
    assign overflow_o    = overflow_q;

    // Words are refused while a flush is pending: the message is already closed.
    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        flush_pend_d = flush_pend_q;
        overflow_d   = overflow_q;
        push_c       = 1'b0;
        word_push_c  = 1'b0;
        push_blk_c   = '0;

        if (data_in_valid_i) begin
            if (flush_pend_q) begin
                overflow_d = 1'b1;
            end else begin
                unique case (state_q)
                    ASM_EMPTY: begin
                        held_d  = data_in_i;
                        state_d = ASM_HALF;
                    end
                    ASM_HALF: begin
                        if (can_push_c) begin
                            push_c      = 1'b1;
                            word_push_c = 1'b1;
                            push_blk_c  = '{data: {held_q, data_in_i}, last: 1'b0};
                            state_d     = ASM_EMPTY;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    default: state_d = ASM_EMPTY;
                endcase
            end
        end

        if (flush_i) begin
            if (flush_pend_q) begin
                overflow_d = 1'b1;
            end else begin
                flush_pend_d = 1'b1;
            end
        end

        // A pending flush closes the message with 10* padding once the FIFO has room.
        if (flush_pend_q && !word_push_c && can_push_c) begin
            push_c       = 1'b1;
            push_blk_c   = (state_q == ASM_HALF)
                         ? '{data: {held_q, ASCON_PAD_WORD}, last: 1'b1}
                         : '{data: {ASCON_PAD_WORD, ASCON_WORD_W'(0)}, last: 1'b1};
            state_d      = ASM_EMPTY;
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ASM_EMPTY;
            held_q       <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (clear_i) begin
            state_q      <= ASM_EMPTY;
            held_q       <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
        end
    end

    ascon_blk_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .push_i     (push_c && !clear_i),
        .push_data_i(push_blk_c),
        .pop_i      (pop_c && !clear_i),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (level_o)
    );

endmodule

// File: tb/tb_ascon_rate_packer.sv
// Directed self-checking bench for ascon_rate_packer with DEPTH=4.
module tb_ascon_rate_packer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             clear_i;
    logic [31:0]      data_in_i;
    logic             data_in_valid_i;
    logic             flush_i;
    logic [63:0]      block_o;
    logic             block_last_o;
    logic             block_valid_o;
    logic             block_ready_i;
    logic [LVL_W-1:0] level_o;
    logic             half_o;
    logic             overflow_o;

    int n_cmp = 0;
    int n_err = 0;

    ascon_rate_packer #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .data_in_i      (data_in_i),
        .data_in_valid_i(data_in_valid_i),
        .flush_i        (flush_i),
        .block_o        (block_o),
        .block_last_o   (block_last_o),
        .block_valid_o  (block_valid_o),
        .block_ready_i  (block_ready_i),
        .level_o        (level_o),
        .half_o         (half_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic word(input logic [31:0] w);
        data_in_i       = w;
        data_in_valid_i = 1'b1;
        tick();
        data_in_valid_i = 1'b0;
    endtask

    task automatic flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    initial begin
        rst_ni          = 1'b0;
        clear_i         = 1'b0;
        data_in_i       = '0;
        data_in_valid_i = 1'b0;
        flush_i         = 1'b0;
        block_ready_i   = 1'b0;
        tick();
        chk("rst_valid", 64'(block_valid_o), 64'd0);
        chk("rst_level", 64'(level_o), 64'd0);
        chk("rst_half", 64'(half_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Two words pack into one block, first word in the upper half.
        block_ready_i = 1'b1;
        word(32'h0123_4567);
        chk("t1_half", 64'(half_o), 64'd1);
        chk("t1_valid0", 64'(block_valid_o), 64'd0);
        word(32'h89AB_CDEF);
        chk("t1_valid", 64'(block_valid_o), 64'd1);
        chk("t1_blk", block_o, 64'h0123_4567_89AB_CDEF);
        chk("t1_last", 64'(block_last_o), 64'd0);
        chk("t1_level", 64'(level_o), 64'd1);
        chk("t1_half0", 64'(half_o), 64'd0);
        tick();
        chk("t1_valid_gone", 64'(block_valid_o), 64'd0);

        // Single word then flush: padded half block.
        word(32'hDEAD_BEEF);
        chk("t2_half", 64'(half_o), 64'd1);
        flush();
        chk("t2_pend_half", 64'(half_o), 64'd1);
        chk("t2_pend_valid", 64'(block_valid_o), 64'd0);
        tick();
        chk("t2_valid", 64'(block_valid_o), 64'd1);
        chk("t2_blk", block_o, 64'hDEAD_BEEF_8000_0000);
        chk("t2_last", 64'(block_last_o), 64'd1);
        chk("t2_half0", 64'(half_o), 64'd0);
        tick();
        chk("t2_valid_gone", 64'(block_valid_o), 64'd0);

        // Two words then flush: full block then pure pad block.
        block_ready_i = 1'b0;
        word(32'h1111_1111);
        word(32'h2222_2222);
        chk("t3_level1", 64'(level_o), 64'd1);
        flush();
        chk("t3_level1b", 64'(level_o), 64'd1);
        tick();
        chk("t3_level2", 64'(level_o), 64'd2);
        chk("t3_blk0", block_o, 64'h1111_1111_2222_2222);
        chk("t3_last0", 64'(block_last_o), 64'd0);
        block_ready_i = 1'b1;
        tick();
        chk("t3_valid1", 64'(block_valid_o), 64'd1);
        chk("t3_blk1", block_o, 64'h8000_0000_0000_0000);
        chk("t3_last1", 64'(block_last_o), 64'd1);
        tick();
        chk("t3_empty", 64'(block_valid_o), 64'd0);
        chk("t3_ovf", 64'(overflow_o), 64'd0);

        // Fill with ready low, then overflow on a HALF word with FIFO full.
        block_ready_i = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) word(32'hA000_0000 + 32'(i));
        chk("t4_level_full", 64'(level_o), 64'(DEPTH));
        chk("t4_ovf0", 64'(overflow_o), 64'd0);
        word(32'hA000_0008);
        word(32'hA000_0009);
        chk("t4_level_hold", 64'(level_o), 64'(DEPTH));
        chk("t4_ovf", 64'(overflow_o), 64'd1);
        chk("t4_half_kept", 64'(half_o), 64'd1);
        block_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("t4_valid%0d", i), 64'(block_valid_o), 64'd1);
            chk($sformatf("t4_blk%0d", i), block_o,
                {32'hA000_0000 + 32'(2 * i), 32'hA000_0000 + 32'(2 * i + 1)});
            tick();
        end
        chk("t4_drained", 64'(block_valid_o), 64'd0);
        chk("t4_half_after", 64'(half_o), 64'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t4_clr_ovf", 64'(overflow_o), 64'd0);
        chk("t4_clr_half", 64'(half_o), 64'd0);

        // Word and flush together in HALF: word absorbed first, no overflow.
        word(32'hC000_0000);
        data_in_i       = 32'hC000_0001;
        data_in_valid_i = 1'b1;
        flush_i         = 1'b1;
        tick();
        data_in_valid_i = 1'b0;
        flush_i         = 1'b0;
        chk("t5_valid", 64'(block_valid_o), 64'd1);
        chk("t5_blk0", block_o, 64'hC000_0000_C000_0001);
        chk("t5_last0", 64'(block_last_o), 64'd0);
        tick();
        chk("t5_valid1", 64'(block_valid_o), 64'd1);
        chk("t5_blk1", block_o, 64'h8000_0000_0000_0000);
        chk("t5_last1", 64'(block_last_o), 64'd1);
        chk("t5_ovf", 64'(overflow_o), 64'd0);
        tick();
        chk("t5_empty", 64'(block_valid_o), 64'd0);

        // Second flush while one is pending is ignored and flagged.
        block_ready_i = 1'b0;
        flush();
        flush();
        chk("t6_ovf", 64'(overflow_o), 64'd1);
        chk("t6_level", 64'(level_o), 64'd1);
        chk("t6_last", 64'(block_last_o), 64'd1);
        tick();
        chk("t6_level_one", 64'(level_o), 64'd1);
        chk("t6_ovf_sticky", 64'(overflow_o), 64'd1);

        // Synchronous clear from HALF with FIFO nonempty.
        word(32'hE000_0000);
        word(32'hE000_0001);
        word(32'hE000_0002);
        chk("t7_level", 64'(level_o), 64'd2);
        chk("t7_half", 64'(half_o), 64'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t7_clr_level", 64'(level_o), 64'd0);
        chk("t7_clr_half", 64'(half_o), 64'd0);
        chk("t7_clr_valid", 64'(block_valid_o), 64'd0);
        chk("t7_clr_ovf", 64'(overflow_o), 64'd0);

        // Asynchronous reset from HALF with FIFO nonempty and overflow set.
        word(32'hF000_0000);
        word(32'hF000_0001);
        word(32'hF000_0002);
        flush();
        flush();
        chk("t8_ovf_set", 64'(overflow_o), 64'd1);
        chk("t8_valid_set", 64'(block_valid_o), 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        chk("t8_rst_level", 64'(level_o), 64'd0);
        chk("t8_rst_half", 64'(half_o), 64'd0);
        chk("t8_rst_valid", 64'(block_valid_o), 64'd0);
        chk("t8_rst_ovf", 64'(overflow_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
